// File: rtl/ps_axi_pkg.sv
// Shared AXI-Lite response codes and address/byte-lane helpers
// for the PS-facing register file.
package ps_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic        ok;
      logic [31:0] idx;
   } idx_t;

   function automatic logic [63:0] strb_merge(
      input logic [63:0] old_v,
      input logic [63:0] data,
      input logic [7:0]  strb
   );
      logic [63:0] r;
      for (int b = 0; b < 8; b++)
         r[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

   function automatic idx_t addr_to_idx(
      input logic [63:0] addr,
      input logic [63:0] base,
      input int          num_regs,
      input int          lg
   );
      idx_t        r;
      logic [63:0] w;
      w     = (addr - base) >> lg;
      r.ok  = (addr >= base) && (w < 64'(num_regs));
      r.idx = w[31:0];
      return r;
   endfunction

endpackage

// File: rtl/axil_wr_collect.sv
// Holds AW and W beats independently and fires one commit
// once both halves of a write are present.
module axil_wr_collect #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic                    busy,
   output logic                    commit,
   output logic [ADDR_WIDTH-1:0]   c_addr,
   output logic [DATA_WIDTH-1:0]   c_data,
   output logic [DATA_WIDTH/8-1:0] c_strb
);

   logic                    aw_held;
   logic                    w_held;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH/8-1:0] strb_q;
   logic                    aw_fire;
   logic                    w_fire;

   assign awready = !rst && !aw_held && !busy;
   assign wready  = !rst && !w_held && !busy;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   // A beat accepted this edge commits immediately if its partner is held
   assign commit = (aw_held || aw_fire) && (w_held || w_fire);
   assign c_addr = aw_held ? addr_q : awaddr;
   assign c_data = w_held ? data_q : wdata;
   assign c_strb = w_held ? strb_q : wstrb;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_fire) begin
            aw_held <= 1'b1;
            addr_q  <= awaddr;
         end
         if (w_fire) begin
            w_held <= 1'b1;
            data_q <= wdata;
            strb_q <= wstrb;
         end
      end
   end

endmodule

// File: rtl/ps_axil_regfile.sv
// AXI4-Lite slave register file between the PS master and PL control,
// with byte strobes, read-only slots and per-register access pulses.
module ps_axil_regfile
   import ps_axi_pkg::*;
#(
   parameter int                             DATA_WIDTH = 32,
   parameter int                             ADDR_WIDTH = 32,
   parameter int                             NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
   input  logic                             ps_clk,
   input  logic                             ps_rst,
   input  logic [ADDR_WIDTH-1:0]            ps_axi_awaddr,
   input  logic                             ps_axi_awvalid,
   output logic                             ps_axi_awready,
   input  logic [DATA_WIDTH-1:0]            ps_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]          ps_axi_wstrb,
   input  logic                             ps_axi_wvalid,
   output logic                             ps_axi_wready,
   output logic [1:0]                       ps_axi_bresp,
   output logic                             ps_axi_bvalid,
   input  logic                             ps_axi_bready,
   input  logic [ADDR_WIDTH-1:0]            ps_axi_araddr,
   input  logic                             ps_axi_arvalid,
   output logic                             ps_axi_arready,
   output logic [DATA_WIDTH-1:0]            ps_axi_rdata,
   output logic [1:0]                       ps_axi_rresp,
   output logic                             ps_axi_rvalid,
   input  logic                             ps_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_in,
   output logic [NUM_REGS-1:0]              wr_pulse,
   output logic [NUM_REGS-1:0]              rd_pulse
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LG     = $clog2(STRB_W);
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                  commit;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]     c_strb;

   axil_wr_collect #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wr (
      .clk     (ps_clk),
      .rst     (ps_rst),
      .awaddr  (ps_axi_awaddr),
      .awvalid (ps_axi_awvalid),
      .awready (ps_axi_awready),
      .wdata   (ps_axi_wdata),
      .wstrb   (ps_axi_wstrb),
      .wvalid  (ps_axi_wvalid),
      .wready  (ps_axi_wready),
      .busy    (ps_axi_bvalid),
      .commit  (commit),
      .c_addr  (c_addr),
      .c_data  (c_data),
      .c_strb  (c_strb)
   );

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] rin    [NUM_REGS];
   idx_t                  w_dec;
   idx_t                  r_dec;
   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      r_idx;
   logic                  w_ro;
   logic                  w_en;
   logic [1:0]            w_resp;
   logic                  ar_fire;
   logic [DATA_WIDTH-1:0] r_data;

   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
         rin[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      w_dec  = addr_to_idx(64'(c_addr), 64'(BASE_ADDR), NUM_REGS, LG);
      w_idx  = IDX_W'(w_dec.idx);
      w_ro   = w_dec.ok && RO_MASK[w_idx];
      w_resp = (!w_dec.ok || w_ro) ? RESP_SLVERR : RESP_OKAY;
      // A zero-strobe write is acknowledged but touches nothing
      w_en   = commit && w_dec.ok && !w_ro && (|c_strb);
   end

   assign ps_axi_arready = !ps_rst && !ps_axi_rvalid;
   assign ar_fire        = ps_axi_arvalid && ps_axi_arready;

   always_comb begin
      r_dec  = addr_to_idx(64'(ps_axi_araddr), 64'(BASE_ADDR), NUM_REGS, LG);
      r_idx  = IDX_W'(r_dec.idx);
      r_data = '0;
      if (r_dec.ok)
         r_data = RO_MASK[r_idx] ? rin[r_idx] : regs_q[r_idx];
   end

   always_ff @(posedge ps_clk) begin
      if (ps_rst) begin
         ps_axi_bvalid <= 1'b0;
         ps_axi_bresp  <= RESP_OKAY;
         wr_pulse      <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= RO_MASK[i] ? '0 : RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         wr_pulse <= '0;
         if (commit) begin
            ps_axi_bvalid <= 1'b1;
            ps_axi_bresp  <= w_resp;
         end else if (ps_axi_bready) begin
            ps_axi_bvalid <= 1'b0;
         end
         if (w_en) begin
            regs_q[w_idx]   <= DATA_WIDTH'(strb_merge(64'(regs_q[w_idx]),
                                          64'(c_data), 8'(c_strb)));
            wr_pulse[w_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge ps_clk) begin
      if (ps_rst) begin
         ps_axi_rvalid <= 1'b0;
         ps_axi_rdata  <= '0;
         ps_axi_rresp  <= RESP_OKAY;
         rd_pulse      <= '0;
      end else begin
         rd_pulse <= '0;
         if (ar_fire) begin
            ps_axi_rvalid <= 1'b1;
            ps_axi_rdata  <= r_data;
            ps_axi_rresp  <= r_dec.ok ? RESP_OKAY : RESP_SLVERR;
            if (r_dec.ok)
               rd_pulse[r_idx] <= 1'b1;
         end else if (ps_axi_rready) begin
            ps_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps_axil_regfile.sv
// Directed bench for ps_axil_regfile: handshakes, strobes, errors,
// read/write ordering and mid-transaction reset.
module tb_ps_axil_regfile;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 16;
   localparam logic [AW-1:0] BASE = 32'h0000_1000;
   localparam logic [NR-1:0] ROM  = 16'h0004;
   localparam logic [NR*DW-1:0] RV = (512'h11 << 96) | 512'hA5A5_A5A5;

   logic            clk = 1'b0;
   logic            ps_rst = 1'b1;
   logic [AW-1:0]   awaddr = '0;
   logic            awvalid = 1'b0;
   logic            awready;
   logic [DW-1:0]   wdata = '0;
   logic [DW/8-1:0] wstrb = '0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready = 1'b0;
   logic [AW-1:0]   araddr = '0;
   logic            arvalid = 1'b0;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready = 1'b0;
   logic [NR*DW-1:0] reg_out;
   logic [NR*DW-1:0] reg_in = '0;
   logic [NR-1:0]   wr_pulse;
   logic [NR-1:0]   rd_pulse;

   int n_cmp = 0;
   int n_fail = 0;
   logic [NR*DW-1:0] exp_out;

   always #5 clk = ~clk;

   ps_axil_regfile #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .BASE_ADDR  (BASE),
      .RO_MASK    (ROM),
      .RESET_VALS (RV)
   ) dut (
      .ps_clk         (clk),
      .ps_rst         (ps_rst),
      .ps_axi_awaddr  (awaddr),
      .ps_axi_awvalid (awvalid),
      .ps_axi_awready (awready),
      .ps_axi_wdata   (wdata),
      .ps_axi_wstrb   (wstrb),
      .ps_axi_wvalid  (wvalid),
      .ps_axi_wready  (wready),
      .ps_axi_bresp   (bresp),
      .ps_axi_bvalid  (bvalid),
      .ps_axi_bready  (bready),
      .ps_axi_araddr  (araddr),
      .ps_axi_arvalid (arvalid),
      .ps_axi_arready (arready),
      .ps_axi_rdata   (rdata),
      .ps_axi_rresp   (rresp),
      .ps_axi_rvalid  (rvalid),
      .ps_axi_rready  (rready),
      .reg_out        (reg_out),
      .reg_in         (reg_in),
      .wr_pulse       (wr_pulse),
      .rd_pulse       (rd_pulse)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      ps_rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
      n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
      n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b want 000", {awready, wready, arready}); end
      n_cmp++; if (reg_out !== RV) begin n_fail++; $display("FAIL rst_regs: got %h want %h", reg_out, RV); end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      n_cmp++; if ({wr_pulse, rd_pulse} !== 32'h0) begin n_fail++; $display("FAIL rst_pulse: got %h want 0", {wr_pulse, rd_pulse}); end
      ps_rst = 1'b0;
      #1;
      n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL post_rst_ready: got %b want 111", {awready, wready, arready}); end
      exp_out = RV;
   endtask

   task automatic test_write_same_cycle;
      awaddr = BASE + 32'h4; awvalid = 1'b1;
      wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      exp_out[63:32] = 32'hDEAD_BEEF;
      n_cmp++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL same_bvalid: got %b want 1", bvalid); end
      n_cmp++; if (bresp !== 2'b00) begin n_fail++; $display("FAIL same_bresp: got %b want 00", bresp); end
      n_cmp++; if (wr_pulse !== 16'h0002) begin n_fail++; $display("FAIL same_wr_pulse: got %h want 0002", wr_pulse); end
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL same_regs: got %h want %h", reg_out, exp_out); end
      n_cmp++; if (awready !== 1'b0) begin n_fail++; $display("FAIL same_awready_busy: got %b want 0", awready); end
      tick();
      n_cmp++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL same_bclear: got %b want 0", bvalid); end
      n_cmp++; if (wr_pulse !== 16'h0) begin n_fail++; $display("FAIL same_pulse_once: got %h want 0", wr_pulse); end
   endtask

   task automatic test_w_first;
      int nb;
      wdata = 32'h0000_00AA; wstrb = 4'h1; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      n_cmp++; if (wready !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready_held: got %b want 0", wready); end
      n_cmp++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_early_b: got %b want 0", bvalid); end
      tick();
      tick();
      awaddr = BASE + 32'h4; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      exp_out[63:32] = 32'hDEAD_BEAA;
      n_cmp++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL wfirst_bvalid: got %b want 1", bvalid); end
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL wfirst_regs: got %h want %h", reg_out, exp_out); end
      n_cmp++; if (wr_pulse !== 16'h0002) begin n_fail++; $display("FAIL wfirst_pulse: got %h want 0002", wr_pulse); end
      nb = 0;
      repeat (4) begin
         tick();
         if (bvalid) nb++;
      end
      n_cmp++; if (nb != 0) begin n_fail++; $display("FAIL wfirst_extra_b: got %0d want 0", nb); end
      n_cmp++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL wfirst_idle_ready: got %b want 11", {awready, wready}); end
   endtask

   task automatic test_slverr;
      logic [AW-1:0] bad [3];
      bad[0] = BASE + 32'h40;
      bad[1] = BASE + 32'h8;
      bad[2] = BASE - 32'h4;
      for (int k = 0; k < 3; k++) begin
         awaddr = bad[k]; awvalid = 1'b1;
         wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
         n_cmp++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL err%0d_bvalid: got %b want 1", k, bvalid); end
         n_cmp++; if (bresp !== 2'b10) begin n_fail++; $display("FAIL err%0d_bresp: got %b want 10", k, bresp); end
         n_cmp++; if (wr_pulse !== 16'h0) begin n_fail++; $display("FAIL err%0d_pulse: got %h want 0", k, wr_pulse); end
         n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL err%0d_regs: got %h want %h", k, reg_out, exp_out); end
         tick();
      end
      awaddr = BASE; awvalid = 1'b1;
      wdata = 32'h1234_5678; wstrb = 4'h0; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      n_cmp++; if (bresp !== 2'b00 || bvalid !== 1'b1) begin n_fail++; $display("FAIL nostrb_resp: got %b/%b want 1/00", bvalid, bresp); end
      n_cmp++; if (wr_pulse !== 16'h0) begin n_fail++; $display("FAIL nostrb_pulse: got %h want 0", wr_pulse); end
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL nostrb_regs: got %h want %h", reg_out, exp_out); end
      tick();
      awaddr = BASE + 32'h13; awvalid = 1'b1;
      wstrb = 4'b0110; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      exp_out[159:128] = 32'h0034_5600;
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL partial_regs: got %h want %h", reg_out, exp_out); end
      n_cmp++; if (wr_pulse !== 16'h0010) begin n_fail++; $display("FAIL partial_pulse: got %h want 0010", wr_pulse); end
      tick();
   endtask

   task automatic test_ro_read;
      reg_in[95:64] = 32'h1234_5678;
      rready = 1'b0;
      araddr = BASE + 32'h8; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      reg_in[95:64] = 32'hCAFE_F00D;
      n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL ro_rvalid: got %b want 1", rvalid); end
      n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ro_rdata: got %h want 12345678", rdata); end
      n_cmp++; if (rresp !== 2'b00) begin n_fail++; $display("FAIL ro_rresp: got %b want 00", rresp); end
      n_cmp++; if (rd_pulse !== 16'h0004) begin n_fail++; $display("FAIL ro_pulse: got %h want 0004", rd_pulse); end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if ({rvalid, arready} !== 2'b10) begin n_fail++; $display("FAIL ro_hold%0d_hs: got %b want 10", k, {rvalid, arready}); end
         n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ro_hold%0d_rdata: got %h want 12345678", k, rdata); end
         n_cmp++; if (rd_pulse !== 16'h0) begin n_fail++; $display("FAIL ro_hold%0d_pulse: got %h want 0", k, rd_pulse); end
      end
      rready = 1'b1;
      tick();
      n_cmp++; if ({rvalid, arready} !== 2'b01) begin n_fail++; $display("FAIL ro_release: got %b want 01", {rvalid, arready}); end
   endtask

   task automatic test_rw_same_edge;
      awaddr = BASE + 32'hC; awvalid = 1'b1;
      wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
      araddr = BASE + 32'hC; arvalid = 1'b1;
      rready = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      exp_out[127:96] = 32'h22;
      n_cmp++; if (rdata !== 32'h11) begin n_fail++; $display("FAIL rw_old_rdata: got %h want 11", rdata); end
      n_cmp++; if (rvalid !== 1'b1 || bvalid !== 1'b1) begin n_fail++; $display("FAIL rw_valids: got %b%b want 11", rvalid, bvalid); end
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL rw_regs: got %h want %h", reg_out, exp_out); end
      tick();
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_cmp++; if (rdata !== 32'h22) begin n_fail++; $display("FAIL rw_new_rdata: got %h want 22", rdata); end
      n_cmp++; if (rd_pulse !== 16'h0008) begin n_fail++; $display("FAIL rw_rd_pulse: got %h want 0008", rd_pulse); end
      tick();
      araddr = BASE + 32'h40; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_cmp++; if (rresp !== 2'b10) begin n_fail++; $display("FAIL oor_rresp: got %b want 10", rresp); end
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rdata); end
      n_cmp++; if (rd_pulse !== 16'h0) begin n_fail++; $display("FAIL oor_pulse: got %h want 0", rd_pulse); end
      tick();
   endtask

   task automatic test_reset_midflight;
      int nb;
      bready = 1'b0;
      awaddr = BASE; awvalid = 1'b1;
      wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      awaddr = BASE + 32'h14;
      n_cmp++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", bvalid); end
      ps_rst = 1'b1;
      tick();
      n_cmp++; if ({bvalid, bresp, rvalid} !== 4'b0) begin n_fail++; $display("FAIL mid_rst_outs: got %b want 0000", {bvalid, bresp, rvalid}); end
      n_cmp++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 000", {awready, wready, arready}); end
      n_cmp++; if (reg_out !== RV) begin n_fail++; $display("FAIL mid_rst_regs: got %h want %h", reg_out, RV); end
      ps_rst = 1'b0; awvalid = 1'b0;
      nb = 0;
      repeat (3) begin
         tick();
         if (bvalid) nb++;
      end
      n_cmp++; if (nb != 0) begin n_fail++; $display("FAIL mid_stale_b: got %0d want 0", nb); end
      awaddr = BASE + 32'h14; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      n_cmp++; if (awready !== 1'b0) begin n_fail++; $display("FAIL mid_aw_held: got %b want 0", awready); end
      ps_rst = 1'b1;
      tick();
      ps_rst = 1'b0;
      #1;
      n_cmp++; if (awready !== 1'b1) begin n_fail++; $display("FAIL mid_aw_cleared: got %b want 1", awready); end
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      n_cmp++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_aw_commit: got %b want 0", bvalid); end
      tick();
      awaddr = BASE + 32'h18; awvalid = 1'b1;
      bready = 1'b1;
      tick();
      awvalid = 1'b0;
      exp_out = RV;
      exp_out[223:192] = 32'h55;
      n_cmp++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL mid_new_bvalid: got %b want 1", bvalid); end
      n_cmp++; if (wr_pulse !== 16'h0040) begin n_fail++; $display("FAIL mid_new_pulse: got %h want 0040", wr_pulse); end
      n_cmp++; if (reg_out !== exp_out) begin n_fail++; $display("FAIL mid_new_regs: got %h want %h", reg_out, exp_out); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_w_first();
      test_slverr();
      test_ro_read();
      test_rw_same_edge();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ps_axil_regfile.md
Name: ps_axil_regfile

Overview:
Parametrised AXI4-Lite slave register file. It replaces direct address and data pass-through from the PS with a fully handshaked endpoint.
- AW and W channels accepted independently.
- Byte strobes honoured.
- SLVERR returned for unmapped or read-only writes.
- Per-register write and read pulses go to PL logic.
- Sits between the PS AXI-Lite master and the PL control logic, in the ps_clk domain.

Parameters:
DATA_WIDTH, 32, AXI data width; must be 32 or 64.
ADDR_WIDTH, 32, AXI address width.
NUM_REGS, 16, number of word registers; must be ≥ 1.
BASE_ADDR, 0, byte address of register 0; must be aligned to NUM_REGS*STRB_W.
RO_MASK, 0, NUM_REGS-bit mask; bit i set means register i is read-only and sourced from reg_in.
RESET_VALS, 0, NUM_REGS*DATA_WIDTH flattened reset values for the read-write registers.

Ports:
ps_clk  in  1  clock
ps_rst  in  1  synchronous, active-high reset
ps_axi_awaddr  in  ADDR_WIDTH  write address
ps_axi_awvalid  in  1  write address valid
ps_axi_awready  out  1  write address ready
ps_axi_wdata  in  DATA_WIDTH  write data
ps_axi_wstrb  in  DATA_WIDTH/8  write byte strobes
ps_axi_wvalid  in  1  write data valid
ps_axi_wready  out  1  write data ready
ps_axi_bresp  out  2  write response
ps_axi_bvalid  out  1  write response valid
ps_axi_bready  in  1  write response ready
ps_axi_araddr  in  ADDR_WIDTH  read address
ps_axi_arvalid  in  1  read address valid
ps_axi_arready  out  1  read address ready
ps_axi_rdata  out  DATA_WIDTH  read data
ps_axi_rresp  out  2  read response
ps_axi_rvalid  out  1  read response valid
ps_axi_rready  in  1  read response ready
reg_out  out  NUM_REGS*DATA_WIDTH  read-write register contents; bits of read-only slots are 0
reg_in  in  NUM_REGS*DATA_WIDTH  read-only register sources, sampled at read accept
wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written
rd_pulse  out  NUM_REGS  one-cycle pulse when register i read data is launched

Behaviour:
- STRB_W = DATA_WIDTH/8.
- Word index = (addr − BASE_ADDR) >> log2(STRB_W).
- Low address bits [log2(STRB_W)-1:0] are ignored.
- An address is in range iff BASE_ADDR ≤ addr < BASE_ADDR + NUM_REGS*STRB_W.

Reset (ps_rst high at a rising edge):
- reg_out = RESET_VALS.
- All valid and ready outputs = 0; bresp = rresp = 0; rdata = 0.
- wr_pulse = rd_pulse = 0.
- Holding registers are cleared; any in-flight transaction is dropped and no response is issued.

Write path (states tracked by aw_held, w_held, bvalid):
- awready = !ps_rst && !aw_held && !bvalid.
- wready = !ps_rst && !w_held && !bvalid.
- An accepted AW or W beat is latched into its holding register. Either may arrive first, any number of cycles apart.
- Commit happens on the first edge where both are held, counting a beat accepted on that same edge. Within that edge, when the cycle's AW/W inputs are latched, they commit the same edge.
  - AW and W accepted together in cycle N: reg_out updated, bvalid = 1 and wr_pulse[i] = 1 visible at cycle N+1.
- Byte merge: for each byte b with wstrb[b] = 1, reg[i] byte b = wdata byte b; other bytes are unchanged.
- Response selection:
  - Out of range: bresp = 2'b10 (SLVERR), no write, no pulse.
  - RO_MASK[i] set: bresp = SLVERR, no write, no pulse.
  - wstrb = 0: bresp = OKAY, no change, no pulse.
  - Otherwise: bresp = 2'b00 (OKAY).
- bvalid and bresp are held until bready. The holding registers clear at commit.
- A new AW/W beat is accepted only after bvalid is cleared, i.e. from the cycle after the bready handshake. There is no overlap.

Read path:
- arready = !ps_rst && !rvalid.
- Accept in cycle N gives rvalid = 1 at N+1, with rdata latched at N+1:
  - reg_in[i] if RO_MASK[i] is set, otherwise reg[i].
  - rresp = OKAY.
- Out of range: rdata = 0, rresp = SLVERR, no pulse.
- rd_pulse[i] = 1 for exactly cycle N+1 on in-range reads.
- rdata and rresp are stable while rvalid && !rready.
- rvalid clears on the rready handshake edge; the next AR can be accepted the following cycle.

Simultaneous events:
- A read accept and a write commit on the same edge to the same register: read returns the pre-write value.
- Read and write paths are otherwise fully independent.

Decomposition:
- Package ps_axi_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Function strb_merge(old, data, strb).
  - Function addr_to_idx, with an in-range flag.
- One natural sub-module: axil_wr_collect, which holds AW/W and produces the commit strobe plus the address and data. The read path stays inline.

Test Plan:
- Reset, then AW = BASE+0x4 and W = 0xDEADBEEF with wstrb = 0xF in the same cycle, bready = 1 → bvalid at +1, bresp = 0, wr_pulse = 0x0002, reg_out[1] = 0xDEADBEEF.
- W first (0x000000AA, wstrb = 0x1), AW 3 cycles later to reg 1 holding 0xDEADBEEF → single commit, reg 1 = 0xDEADBEAA, exactly one bvalid.
- Write to BASE + NUM_REGS*4, and write to a register with RO_MASK[2] set → bresp = 2'b10 for both, reg_out unchanged, no wr_pulse.
- Read reg 2 (RO) with reg_in[2] = 0x12345678 and rready held low 5 cycles → rvalid held, rdata = 0x12345678, arready = 0 until the handshake, rd_pulse[2] one cycle only.
- Read of reg 3 (value 0x11) accepted on the same edge as a write-commit of 0x22 to reg 3 → rdata = 0x11, subsequent read = 0x22.
- Assert ps_rst with AW held and bvalid pending → all outputs are at reset values next cycle, reg_out = RESET_VALS, no stale bvalid after deassert.
